// File: rtl/nand_target.sv
// nand_target: NAND flash target model serving ID, status and page reads from a
// byte-wide backing store. Host strobes are synchronised into clk before use.
`timescale 1ns/1ps
module nand_target #(
  parameter logic [39:0] ID_BYTES    = 40'h86_03_FF_E5_2C,
  parameter int          PAGE_SIZE   = 2112,
  parameter int          TRST_CYCLES = 16,
  parameter int          TR_CYCLES   = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        nand_cle,
  input  logic        nand_ale,
  input  logic        nand_nce,
  input  logic        nand_nwe,
  input  logic        nand_nre,
  input  logic        nand_nwp,
  input  logic [7:0]  nand_din,
  output logic [7:0]  nand_dout,
  output logic        nand_doe,
  output logic        nand_rnb,
  output logic [23:0] mem_row,
  output logic [11:0] mem_col,
  input  logic [7:0]  mem_rdata
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ADDR_ID    = 3'd1,
    ADDR_RD    = 3'd2,
    WAIT_CONF  = 3'd3,
    ID_OUT     = 3'd4,
    STATUS_OUT = 3'd5,
    BUSY       = 3'd6,
    DATA_OUT   = 3'd7
  } state_t;

  localparam logic [7:0]  CMD_READ   = 8'h00;
  localparam logic [7:0]  CMD_CONF   = 8'h30;
  localparam logic [7:0]  CMD_STATUS = 8'h70;
  localparam logic [7:0]  CMD_ID     = 8'h90;
  localparam logic [7:0]  CMD_RESET  = 8'hFF;
  localparam logic [11:0] COL_LAST   = 12'(PAGE_SIZE - 1);

  function automatic logic [7:0] id_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    id_byte = ID_BYTES[7:0];
      3'd1:    id_byte = ID_BYTES[15:8];
      3'd2:    id_byte = ID_BYTES[23:16];
      3'd3:    id_byte = ID_BYTES[31:24];
      3'd4:    id_byte = ID_BYTES[39:32];
      default: id_byte = 8'h00;
    endcase
  endfunction

  logic s_nwe_r, d_nwe_r, s_nre_r, d_nre_r;
  state_t state_r, saved_r, nxt_state_s, nxt_saved_s, done_state_s;
  logic        busy_on_r, busy_rst_r, nxt_busy_on_s, nxt_busy_rst_s;
  logic [15:0] busy_cnt_r, nxt_cnt_s;
  logic [2:0]  addr_cnt_r, nxt_addr_cnt_s, id_idx_r, nxt_id_idx_s;
  logic [23:0] row_r, nxt_row_s;
  logic [11:0] col_r, nxt_col_s;
  logic [7:0]  dout_r;
  logic        oe_en_r, rnb_r;
  logic        we_ev_s, re_ev_s, cmd_ev_s, adr_ev_s, rst_busy_s;

  // Two-stage strobe synchronisers; an event is the rising edge seen between stages
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_nwe_r <= 1'b1;
      d_nwe_r <= 1'b1;
      s_nre_r <= 1'b1;
      d_nre_r <= 1'b1;
    end else begin
      s_nwe_r <= nand_nwe;
      d_nwe_r <= s_nwe_r;
      s_nre_r <= nand_nre;
      d_nre_r <= s_nre_r;
    end
  end

  assign we_ev_s    = s_nwe_r & ~d_nwe_r & ~nand_nce;
  assign re_ev_s    = s_nre_r & ~d_nre_r & ~nand_nce;
  assign cmd_ev_s   = we_ev_s & nand_cle & ~nand_ale;
  assign adr_ev_s   = we_ev_s & ~nand_cle & nand_ale;
  assign rst_busy_s = busy_on_r & busy_rst_r;

  // Next-state: busy timer, read/address events, then commands (commands take priority)
  always_comb begin
    nxt_state_s    = state_r;
    nxt_saved_s    = saved_r;
    nxt_busy_on_s  = busy_on_r;
    nxt_busy_rst_s = busy_rst_r;
    nxt_cnt_s      = busy_cnt_r;
    nxt_addr_cnt_s = addr_cnt_r;
    nxt_id_idx_s   = id_idx_r;
    nxt_row_s      = row_r;
    nxt_col_s      = col_r;
    done_state_s   = busy_rst_r ? IDLE : DATA_OUT;

    if (busy_on_r) begin
      // A status read may have parked BUSY in saved_r; completion lands there instead
      if (busy_cnt_r == 16'd0) begin
        nxt_busy_on_s = 1'b0;
        if (state_r == BUSY) begin
          nxt_state_s = done_state_s;
        end else if (saved_r == BUSY) begin
          nxt_saved_s = done_state_s;
        end else begin
        end
      end else begin
        nxt_cnt_s = busy_cnt_r - 16'd1;
      end
    end else if (re_ev_s && state_r == ID_OUT) begin
      if (id_idx_r < 3'd5) nxt_id_idx_s = id_idx_r + 3'd1;
      else nxt_id_idx_s = id_idx_r;
    end else if (re_ev_s && state_r == DATA_OUT) begin
      if (col_r == COL_LAST) nxt_col_s = 12'd0;
      else nxt_col_s = col_r + 12'd1;
    end else if (adr_ev_s && state_r == ADDR_ID) begin
      nxt_state_s  = ID_OUT;
      nxt_id_idx_s = 3'd0;
    end else if (adr_ev_s && state_r == ADDR_RD && addr_cnt_r < 3'd5) begin
      nxt_addr_cnt_s = addr_cnt_r + 3'd1;
      case (addr_cnt_r)
        3'd0: nxt_col_s[7:0]    = nand_din;
        3'd1: nxt_col_s[11:8]   = nand_din[3:0];
        3'd2: nxt_row_s[7:0]    = nand_din;
        3'd3: nxt_row_s[15:8]   = nand_din;
        3'd4: begin
          nxt_row_s[23:16] = nand_din;
          nxt_state_s      = WAIT_CONF;
        end
        default: nxt_row_s = row_r;
      endcase
    end else begin
    end

    if (cmd_ev_s) begin
      if (nand_din != CMD_CONF) nxt_addr_cnt_s = 3'd0;
      else nxt_addr_cnt_s = addr_cnt_r;

      if (nand_din == CMD_RESET) begin
        nxt_state_s    = BUSY;
        nxt_busy_on_s  = 1'b1;
        nxt_busy_rst_s = 1'b1;
        nxt_cnt_s      = 16'(TRST_CYCLES - 1);
        nxt_row_s      = 24'd0;
        nxt_col_s      = 12'd0;
      end else if (rst_busy_s) begin
      end else if (nand_din == CMD_STATUS) begin
        if (state_r != STATUS_OUT) nxt_saved_s = nxt_state_s;
        else nxt_saved_s = nxt_saved_s;
        nxt_state_s = STATUS_OUT;
      end else if (state_r == STATUS_OUT && nand_din == CMD_READ) begin
        nxt_state_s = nxt_saved_s;
      end else if (busy_on_r) begin
      end else begin
        case (nand_din)
          CMD_READ: nxt_state_s = ADDR_RD;
          CMD_ID:   nxt_state_s = ADDR_ID;
          CMD_CONF: begin
            if (state_r == WAIT_CONF) begin
              nxt_state_s    = BUSY;
              nxt_busy_on_s  = 1'b1;
              nxt_busy_rst_s = 1'b0;
              nxt_cnt_s      = 16'(TR_CYCLES - 1);
            end else begin
              nxt_state_s = state_r;
            end
          end
          default:  nxt_state_s = IDLE;
        endcase
      end
    end else begin
    end
  end

  // State, datapath and registered output drivers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      saved_r    <= IDLE;
      busy_on_r  <= 1'b0;
      busy_rst_r <= 1'b0;
      busy_cnt_r <= 16'd0;
      addr_cnt_r <= 3'd0;
      id_idx_r   <= 3'd0;
      row_r      <= 24'd0;
      col_r      <= 12'd0;
      dout_r     <= 8'h00;
      oe_en_r    <= 1'b0;
      rnb_r      <= 1'b1;
    end else begin
      state_r    <= nxt_state_s;
      saved_r    <= nxt_saved_s;
      busy_on_r  <= nxt_busy_on_s;
      busy_rst_r <= nxt_busy_rst_s;
      busy_cnt_r <= nxt_cnt_s;
      addr_cnt_r <= nxt_addr_cnt_s;
      id_idx_r   <= nxt_id_idx_s;
      row_r      <= nxt_row_s;
      col_r      <= nxt_col_s;
      rnb_r      <= ~nxt_busy_on_s;
      oe_en_r    <= (state_r == ID_OUT) || (state_r == STATUS_OUT) || (state_r == DATA_OUT);
      case (state_r)
        ID_OUT:     dout_r <= id_byte(id_idx_r);
        STATUS_OUT: dout_r <= {nand_nwp, rnb_r, rnb_r, 5'b00000};
        DATA_OUT:   dout_r <= mem_rdata;
        default:    dout_r <= 8'h00;
      endcase
    end
  end

  assign nand_dout = dout_r;
  assign nand_doe  = oe_en_r & ~nand_nce & ~nand_nre;
  assign nand_rnb  = rnb_r;
  assign mem_row   = row_r;
  assign mem_col   = col_r;

endmodule

// File: tb/tb_nand_target.sv
// Scoreboard bench for nand_target: stimulus queues expected read bytes, a negedge
// monitor compares each byte when the target releases the bus.
`timescale 1ns/1ps
module tb_nand_target;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        nand_cle = 1'b0, nand_ale = 1'b0;
  logic        nand_nce = 1'b0, nand_nwe = 1'b1, nand_nre = 1'b1, nand_nwp = 1'b1;
  logic [7:0]  nand_din = 8'h00;
  logic [7:0]  nand_dout;
  logic        nand_doe, nand_rnb;
  logic [23:0] mem_row;
  logic [11:0] mem_col;
  logic [7:0]  mem_rdata = 8'h00;

  int tests = 0;
  int fails = 0;
  int busy_cycles = 0;
  logic [7:0] exp_q[$];
  string      name_q[$];
  logic       seen = 1'b0;
  logic [7:0] last_dout = 8'h00;
  logic [7:0] mon_exp;
  string      mon_name;

  nand_target dut (
    .clk(clk), .reset(reset), .nand_cle(nand_cle), .nand_ale(nand_ale),
    .nand_nce(nand_nce), .nand_nwe(nand_nwe), .nand_nre(nand_nre), .nand_nwp(nand_nwp),
    .nand_din(nand_din), .nand_dout(nand_dout), .nand_doe(nand_doe), .nand_rnb(nand_rnb),
    .mem_row(mem_row), .mem_col(mem_col), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Backing store: byte = col[7:0] ^ {col[11:8], row[3:0]}, one clk latency
  function automatic logic [7:0] mem_fn(input logic [23:0] row, input logic [11:0] col);
    return col[7:0] ^ {col[11:8], row[3:0]};
  endfunction
  always @(posedge clk) mem_rdata <= mem_fn(mem_row, mem_col);

  // Monitor: a byte is presented while doe=1; compare when doe falls
  always @(negedge clk) begin
    if (!nand_rnb) busy_cycles++;
    if (nand_doe) begin
      last_dout = nand_dout;
      seen = 1'b1;
    end else if (seen) begin
      seen = 1'b0;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_read: got %02h, nothing expected", last_dout);
      end else begin
        mon_exp  = exp_q.pop_front();
        mon_name = name_q.pop_front();
        if (last_dout !== mon_exp) begin
          fails++;
          $display("FAIL %s: got %02h expected %02h", mon_name, last_dout, mon_exp);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic wr(input logic cle, input logic ale, input logic [7:0] d);
    nand_cle = cle;
    nand_ale = ale;
    nand_din = d;
    nand_nwe = 1'b0;
    tick(3);
    nand_nwe = 1'b1;
    tick(3);
    nand_cle = 1'b0;
    nand_ale = 1'b0;
  endtask

  task automatic cmd(input logic [7:0] d);
    wr(1'b1, 1'b0, d);
  endtask

  task automatic adr(input logic [7:0] d);
    wr(1'b0, 1'b1, d);
  endtask

  task automatic rd();
    nand_nre = 1'b0;
    tick(5);
    nand_nre = 1'b1;
    tick(4);
  endtask

  task automatic expect_rd(input string n, input logic [7:0] v);
    name_q.push_back(n);
    exp_q.push_back(v);
    rd();
  endtask

  task automatic wait_ready(input int limit);
    int k;
    k = 0;
    while (nand_rnb !== 1'b1 && k < limit) begin
      tick(1);
      k++;
    end
    check("ready_within_bound", {31'd0, nand_rnb}, 32'd1);
  endtask

  task automatic read_addr();
    adr(8'h3E); adr(8'h08); adr(8'h05); adr(8'h00); adr(8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    @(negedge clk);
    check("reset_rnb", {31'd0, nand_rnb}, 32'd1);
    check("reset_doe", {31'd0, nand_doe}, 32'd0);
    check("reset_dout", {24'd0, nand_dout}, 32'h00);
    check("reset_row", {8'd0, mem_row}, 32'd0);
    check("reset_col", {20'd0, mem_col}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    tick(2);

    // 0xFF: busy for 16 clks, then status
    busy_cycles = 0;
    cmd(8'hFF);
    wait_ready(100);
    check("trst_busy_cycles", busy_cycles, 32'd16);
    cmd(8'h70);
    expect_rd("status_ready_wp1", 8'hE0);
    nand_nwp = 1'b0;
    tick(2);
    expect_rd("status_live_wp0", 8'h60);
    nand_nwp = 1'b1;

    // Read ID with saturation
    cmd(8'h90);
    adr(8'h00);
    expect_rd("id0", 8'h2C);
    expect_rd("id1", 8'hE5);
    expect_rd("id2", 8'hFF);
    expect_rd("id3", 8'h03);
    expect_rd("id4", 8'h86);
    expect_rd("id5_sat", 8'h00);

    // Page read with column wrap
    cmd(8'h00);
    read_addr();
    busy_cycles = 0;
    cmd(8'h30);
    wait_ready(200);
    check("tr_busy_cycles", busy_cycles, 32'd64);
    tick(2);
    check("read_row", {8'd0, mem_row}, 32'd5);
    check("read_col", {20'd0, mem_col}, 32'h83E);
    expect_rd("data_83e", 8'hBB);
    expect_rd("data_83f", 8'hBA);
    expect_rd("data_wrap_000", 8'h05);
    check("wrap_row_kept", {8'd0, mem_row}, 32'd5);
    check("wrap_col", {20'd0, mem_col}, 32'h001);

    // Status during read busy, then resume
    cmd(8'h00);
    read_addr();
    cmd(8'h30);
    cmd(8'h70);
    expect_rd("status_busy", 8'h80);
    wait_ready(200);
    tick(2);
    expect_rd("status_after_busy", 8'hE0);
    cmd(8'h00);
    expect_rd("resume_data_83e", 8'hBB);
    check("resume_col", {20'd0, mem_col}, 32'h83F);

    // Strobes with nce high are ignored and doe stays low
    nand_nce = 1'b1;
    cmd(8'h90);
    nand_nre = 1'b0;
    tick(2);
    @(negedge clk);
    check("nce_doe_low", {31'd0, nand_doe}, 32'd0);
    @(posedge clk); #1;
    nand_nre = 1'b1;
    tick(4);
    nand_nce = 1'b0;
    tick(1);
    check("nce_col_kept", {20'd0, mem_col}, 32'h83F);
    expect_rd("nce_still_data", 8'hBA);

    // Unknown command returns to idle; 0x30 outside WAIT_CONF is ignored
    cmd(8'h00);
    adr(8'h3E);
    cmd(8'h55);
    cmd(8'h30);
    tick(3);
    check("conf_ignored_rnb", {31'd0, nand_rnb}, 32'd1);
    check("partial_addr_col", {20'd0, mem_col}, 32'h03E);
    cmd(8'h90);
    adr(8'h00);
    expect_rd("id_after_unknown", 8'h2C);

    // Reset mid-busy aborts immediately
    cmd(8'hFF);
    tick(4);
    check("busy_before_reset", {31'd0, nand_rnb}, 32'd0);
    reset = 1'b1;
    #2;
    check("async_reset_rnb", {31'd0, nand_rnb}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("post_reset_rnb", {31'd0, nand_rnb}, 32'd1);
    tick(20);
    check("post_reset_idle_rnb", {31'd0, nand_rnb}, 32'd1);

    tick(2);
    while (exp_q.size() != 0) begin
      tests++;
      fails++;
      mon_name = name_q.pop_front();
      mon_exp  = exp_q.pop_front();
      $display("FAIL %s: no byte presented, expected %02h", mon_name, mon_exp);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/nand_target.md
NAND_TARGET -- requirements
Module: nand_target

Interface
REQ-001 Parameter ID_BYTES, default 40'h86_03_FF_E5_2C, five ID bytes, byte 0 in bits [7:0].
REQ-002 Parameter PAGE_SIZE, default 2112, bytes per page including spare; column wrap point.
REQ-003 Parameter TRST_CYCLES, default 16, clk cycles busy after RESET command.
REQ-004 Parameter TR_CYCLES, default 64, clk cycles busy after READ confirm (0x30).
REQ-005 clk  in  1  single clock; every register in the block is clocked on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 nand_cle, nand_ale  in  1 each  command/address latch enables.
REQ-008 nand_nce, nand_nwe, nand_nre, nand_nwp  in  1 each  active-low chip enable, write strobe, read strobe, write protect.
REQ-009 nand_din  in  8  bus value as driven by the host.
REQ-010 nand_dout  out  8  bus value driven by this target.
REQ-011 nand_doe  out  1  output enable for nand_dout (tristate control).
REQ-012 nand_rnb  out  1  ready/busy; 1 = ready.
REQ-013 mem_row  out  24  page row address to backing store.
REQ-014 mem_col  out  12  byte column to backing store.
REQ-015 mem_rdata  in  8  backing-store byte; valid one clk after mem_row/mem_col change.

Function
REQ-016 nand_nwe and nand_nre shall each be registered twice (s_x, d_x); a strobe event shall be s_x=1 & d_x=0; the event acts on that clk edge and is visible on outputs one clk later.
REQ-017 Strobe events while nand_nce=1 shall be ignored; nand_doe shall be 0 whenever nand_nce=1 or nand_nre=1.
REQ-018 nwe event with cle=1, ale=0 latches nand_din as a command; with cle=0, ale=1 as an address byte; any other cle/ale combination is ignored.
REQ-019 States: IDLE, ADDR_ID, ADDR_RD, WAIT_CONF, ID_OUT, STATUS_OUT, BUSY, DATA_OUT.
REQ-020 Command 0xFF in any state shall enter BUSY, drive nand_rnb=0 for exactly TRST_CYCLES clks, clear row/column to 0, then enter IDLE.
REQ-021 Command 0x90 shall enter ADDR_ID; one address byte shall move to ID_OUT with ID index 0; the address value is ignored.
REQ-022 ID_OUT: nand_dout = ID byte[index]; each nre event increments index; index >= 5 shall output 0x00, saturating.
REQ-023 Command 0x70 in any state except during a 0xFF-initiated reset sequence shall enter STATUS_OUT, remembering the interrupted state.
REQ-024 Status byte = {nand_nwp, rnb, rnb, 5'b0}; value is live and updates while STATUS_OUT is held.
REQ-025 Command 0x00 then any further command other than 0x30 resets the 5-byte address counter.
REQ-026 Command 0x00 shall enter ADDR_RD; address bytes in order: col[7:0], col[11:8] (upper 4 bits ignored), row[7:0], row[15:8], row[23:16]; the fifth byte moves to WAIT_CONF.
REQ-027 Address bytes beyond five are ignored; command 0x30 in WAIT_CONF shall enter BUSY for TR_CYCLES clks, then enter DATA_OUT.
REQ-028 Command 0x30 outside WAIT_CONF is ignored.
REQ-029 Command 0x00 received in STATUS_OUT returns to the remembered state; if that state was DATA_OUT, the column is unchanged.
REQ-030 DATA_OUT: mem_row/mem_col = latched address; nand_dout = mem_rdata; each nre event increments column.
REQ-031 Column equal to PAGE_SIZE-1 shall wrap to 0; mem_row is unchanged on wrap.
REQ-032 Unknown command codes shall return to IDLE with no other effect.
REQ-033 During BUSY, only 0xFF (restarts TRST count) and 0x70 are accepted; nwe events otherwise ignored, nre events ignored.
REQ-034 nand_doe=1 only in ID_OUT, STATUS_OUT, DATA_OUT with nand_nce=0 and nand_nre=0.
REQ-035 nand_nwp does not alter reads; it only sets status bit 7.

Reset
REQ-036 reset=1 shall asynchronously force: state IDLE, nand_rnb=1, nand_doe=0, nand_dout=0x00, mem_row=0, mem_col=0, all counters 0, strobe sync registers = 1.
REQ-037 Reset asserted mid-BUSY or mid-DATA_OUT shall abort immediately; the first clk after deassertion is in IDLE with nand_rnb=1.

Verification
REQ-038 Cmd 0xFF -> nand_rnb low exactly 16 clks, then 1; status read returns 0xE0 with nwp=1.
REQ-039 Cmd 0x90, addr 0x00, 6 nre pulses -> 2C, E5, FF, 03, 86, 00.
REQ-040 Cmd 0x00, addr 3E,08,05,00,00, cmd 0x30 -> rnb low 64 clks; mem_row=5, mem_col=0x83E; reads advance to 0x83F, then wrap to 0x000.
REQ-041 Cmd 0x70 during read BUSY -> status 0x80; after ready -> 0xE0; cmd 0x00 resumes DATA_OUT at the same column.
REQ-042 nce=1 with nwe/nre toggling -> no state change, nand_doe=0; reset pulse mid-BUSY -> rnb=1 on next clk.
